instruction_decode_stage: RTL and testbench

ID stage of the five-stage 32-bit MIPS-subset pipeline. It holds the IF/ID pipeline register, decodes the opcode into control signals, and reads two operands from a 32×32 register file. It also resolves `beq` early (equality compare and branch target) and detects read-after-write hazards with a per-register pending scoreboard. Writeback from WB enters through a dedicated write port.

---
 rtl/instruction_decode_stage.sv | 187 ++++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode_stage
// Purpose  : ID stage of a five-stage 32-bit MIPS-subset pipeline. Holds the
//            IF/ID register, decodes control, reads a 32x32 register file
//            with write-through, resolves beq early and detects RAW hazards
//            with a per-register pending scoreboard.
// Ports    : clk, reset                  - clock, sync active-high reset
//            if_instruction, if_pc_plus4 - fetched instruction and PC+4
//            flush_d                     - squash IF/ID (load NOP)
//            wb_reg_write/_write_reg/_result - writeback port
//            stall_f, hazard_detected    - stall request / hazard flag
//            rs_d, rt_d, rd_d            - register fields
//            data1, data2, write_data_d, sign_imm_d - operands
//            pc_branch_d, equal_d, pc_src_d         - early branch
//            *_d control outputs, alu_op_d, alu_control_d
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc_plus4,
    input  logic        flush_d,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_result,
    output logic        stall_f,
    output logic        hazard_detected,
    output logic [4:0]  rs_d,
    output logic [4:0]  rt_d,
    output logic [4:0]  rd_d,
    output logic [31:0] data1,
    output logic [31:0] write_data_d,
    output logic [31:0] data2,
    output logic [31:0] sign_imm_d,
    output logic [31:0] pc_branch_d,
    output logic        equal_d,
    output logic        pc_src_d,
    output logic        reg_write_d,
    output logic        mem_to_reg_d,
    output logic        mem_write_d,
    output logic        alu_src_d,
    output logic        reg_dst_d,
    output logic        branch_d,
    output logic [1:0]  alu_op_d,
    output logic [3:0]  alu_control_d
);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_regs [32];
    logic [31:0] r_pending;

    logic        w_is_rtype, w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_valid;
    logic        w_uses_rs, w_uses_rt;
    logic        w_wb_we;
    logic        w_rs_busy, w_rt_busy;
    logic        w_raw_reg_write;
    logic [1:0]  w_raw_alu_op;
    logic [3:0]  w_alu_ctrl;
    logic [4:0]  w_dest;
    logic [31:0] w_set, w_clr;

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || flush_d) begin
            r_instr    <= 32'h0;
            r_pc_plus4 <= 32'h0;
        end else if (!hazard_detected) begin
            r_instr    <= if_instruction;
            r_pc_plus4 <= if_pc_plus4;
        end
    end

    assign rs_d = r_instr[25:21];
    assign rt_d = r_instr[20:16];
    assign rd_d = r_instr[15:11];
    assign sign_imm_d = {{16{r_instr[15]}}, r_instr[15:0]};

    // ------------------------------------------------------------------
    // Opcode classification; the all-zero word is a NOP, not an R-type
    // ------------------------------------------------------------------
    assign w_is_rtype = (r_instr[31:26] == c_op_rtype) && (r_instr != 32'h0);
    assign w_is_lw    = (r_instr[31:26] == c_op_lw);
    assign w_is_sw    = (r_instr[31:26] == c_op_sw);
    assign w_is_beq   = (r_instr[31:26] == c_op_beq);
    assign w_is_addi  = (r_instr[31:26] == c_op_addi);
    assign w_valid    = w_is_rtype | w_is_lw | w_is_sw | w_is_beq | w_is_addi;

    assign w_uses_rs  = w_valid;
    assign w_uses_rt  = w_is_rtype | w_is_sw | w_is_beq;

    assign w_raw_reg_write = w_is_rtype | w_is_lw | w_is_addi;
    assign w_raw_alu_op    = w_is_rtype ? 2'b10 : (w_is_beq ? 2'b01 : 2'b00);
    assign w_dest          = w_is_rtype ? rd_d : rt_d;

    always_comb begin
        w_alu_ctrl = 4'b0010;
        case (w_raw_alu_op)
            2'b00: w_alu_ctrl = 4'b0010;
            2'b01: w_alu_ctrl = 4'b0110;
            default: begin
                case (r_instr[5:0])
                    6'b100000: w_alu_ctrl = 4'b0010;
                    6'b100010: w_alu_ctrl = 4'b0110;
                    6'b100100: w_alu_ctrl = 4'b0000;
                    6'b100101: w_alu_ctrl = 4'b0001;
                    6'b101010: w_alu_ctrl = 4'b0111;
                    default:   w_alu_ctrl = 4'b0010;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file: combinational read with write-through bypass
    // ------------------------------------------------------------------
    assign w_wb_we = wb_reg_write && (wb_write_reg != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
        end else if (w_wb_we) begin
            r_regs[wb_write_reg] <= wb_result;
        end
    end

    assign data1 = (rs_d == 5'd0) ? 32'h0 :
                   (w_wb_we && (wb_write_reg == rs_d)) ? wb_result : r_regs[rs_d];
    assign write_data_d = (rt_d == 5'd0) ? 32'h0 :
                   (w_wb_we && (wb_write_reg == rt_d)) ? wb_result : r_regs[rt_d];

    // ------------------------------------------------------------------
    // Scoreboard. A register being written back this cycle is no longer
    // busy, so the stall releases in the same cycle the bypass delivers it.
    // ------------------------------------------------------------------
    assign w_rs_busy = r_pending[rs_d] && !(w_wb_we && (wb_write_reg == rs_d));
    assign w_rt_busy = r_pending[rt_d] && !(w_wb_we && (wb_write_reg == rt_d));
    assign hazard_detected = (w_uses_rs && w_rs_busy) || (w_uses_rt && w_rt_busy);
    assign stall_f = hazard_detected;

    always_comb begin
        w_set = 32'h0;
        w_clr = 32'h0;
        if (w_raw_reg_write && !hazard_detected && !flush_d && (w_dest != 5'd0))
            w_set[w_dest] = 1'b1;
        if (w_wb_we)
            w_clr[wb_write_reg] = 1'b1;
    end

    // Set is applied after clear so a same-register collision keeps the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 32'h0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | w_set) & 32'hFFFF_FFFE;
        end
    end

    // ------------------------------------------------------------------
    // Control outputs, squashed to a bubble while stalled
    // ------------------------------------------------------------------
    assign reg_write_d   = w_raw_reg_write & ~hazard_detected;
    assign mem_to_reg_d  = w_is_lw & ~hazard_detected;
    assign mem_write_d   = w_is_sw & ~hazard_detected;
    assign alu_src_d     = (w_is_lw | w_is_sw | w_is_addi) & ~hazard_detected;
    assign reg_dst_d     = w_is_rtype & ~hazard_detected;
    assign branch_d      = w_is_beq & ~hazard_detected;
    assign alu_op_d      = hazard_detected ? 2'b00 : w_raw_alu_op;
    assign alu_control_d = (w_valid && !hazard_detected) ? w_alu_ctrl : 4'b0000;

    assign data2       = alu_src_d ? sign_imm_d : write_data_d;
    assign pc_branch_d = r_pc_plus4 + {sign_imm_d[29:0], 2'b00};
    assign equal_d     = (data1 == write_data_d);
    assign pc_src_d    = branch_d & equal_d & ~hazard_detected;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decode_stage
// Purpose  : Directed self-checking bench for instruction_decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush_d, wb_reg_write;
    logic [31:0] if_instruction, if_pc_plus4, wb_result;
    logic [4:0]  wb_write_reg;
    logic        stall_f, hazard_detected, equal_d, pc_src_d;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic [31:0] data1, write_data_d, data2, sign_imm_d, pc_branch_d;
    logic        reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d, branch_d;
    logic [1:0]  alu_op_d;
    logic [3:0]  alu_control_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_decode_stage dut (
        .clk(clk), .reset(reset), .if_instruction(if_instruction),
        .if_pc_plus4(if_pc_plus4), .flush_d(flush_d), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_result(wb_result), .stall_f(stall_f),
        .hazard_detected(hazard_detected), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .data1(data1), .write_data_d(write_data_d), .data2(data2),
        .sign_imm_d(sign_imm_d), .pc_branch_d(pc_branch_d), .equal_d(equal_d),
        .pc_src_d(pc_src_d), .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
        .mem_write_d(mem_write_d), .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d),
        .branch_d(branch_d), .alu_op_d(alu_op_d), .alu_control_d(alu_control_d)
    );

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush_d = 1'b0; wb_reg_write = 1'b0; wb_write_reg = 5'd0;
        wb_result = 32'h0; if_instruction = 32'h0; if_pc_plus4 = 32'h0;
        step(); step();
        reset = 1'b0;
        total++; if (reg_write_d !== 1'b0) begin bad++; $display("FAIL reset_reg_write got=%b exp=0", reg_write_d); end
        total++; if (hazard_detected !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", hazard_detected); end
        total++; if (pc_branch_d !== 32'h0) begin bad++; $display("FAIL reset_pc_branch got=%h exp=0", pc_branch_d); end
        total++; if (equal_d !== 1'b1) begin bad++; $display("FAIL reset_equal got=%b exp=1", equal_d); end
        total++; if (pc_src_d !== 1'b0) begin bad++; $display("FAIL reset_pc_src got=%b exp=0", pc_src_d); end
        total++; if (data1 !== 32'h0) begin bad++; $display("FAIL reset_data1 got=%h exp=0", data1); end
    endtask

    task automatic test_rtype();
        if_instruction = 32'h0022_1820; if_pc_plus4 = 32'h4;   // add $3,$1,$2
        step();
        if_instruction = 32'h0;
        total++; if (reg_write_d !== 1'b1) begin bad++; $display("FAIL add_reg_write got=%b exp=1", reg_write_d); end
        total++; if (reg_dst_d !== 1'b1) begin bad++; $display("FAIL add_reg_dst got=%b exp=1", reg_dst_d); end
        total++; if (alu_op_d !== 2'b10) begin bad++; $display("FAIL add_alu_op got=%b exp=10", alu_op_d); end
        total++; if (alu_control_d !== 4'b0010) begin bad++; $display("FAIL add_alu_ctrl got=%b exp=0010", alu_control_d); end
        total++; if ({rs_d, rt_d, rd_d} !== {5'd1, 5'd2, 5'd3}) begin bad++; $display("FAIL add_fields got=%0d,%0d,%0d exp=1,2,3", rs_d, rt_d, rd_d); end
        total++; if (hazard_detected !== 1'b0) begin bad++; $display("FAIL add_hazard got=%b exp=0", hazard_detected); end
    endtask

    task automatic test_alu_funct();
        logic [5:0] functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        logic [3:0] exps   [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            if_instruction = {26'h0, functs[i]};   // rs=rt=rd=0
            step();
            total++; if (alu_control_d !== exps[i]) begin bad++; $display("FAIL funct_%h got=%b exp=%b", functs[i], alu_control_d, exps[i]); end
        end
        if_instruction = 32'h0;
        step();
    endtask

    task automatic test_branch();
        wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_result = 32'd5;
        step();
        wb_write_reg = 5'd2;
        step();
        wb_reg_write = 1'b0;
        if_instruction = 32'h1022_0003; if_pc_plus4 = 32'h100;   // beq $1,$2,+3
        step();
        if_instruction = 32'h0;
        total++; if (data1 !== 32'd5) begin bad++; $display("FAIL beq_data1 got=%h exp=5", data1); end
        total++; if (equal_d !== 1'b1) begin bad++; $display("FAIL beq_equal got=%b exp=1", equal_d); end
        total++; if (pc_src_d !== 1'b1) begin bad++; $display("FAIL beq_pc_src got=%b exp=1", pc_src_d); end
        total++; if (pc_branch_d !== 32'h10C) begin bad++; $display("FAIL beq_target got=%h exp=10c", pc_branch_d); end
        total++; if (alu_control_d !== 4'b0110) begin bad++; $display("FAIL beq_alu_ctrl got=%b exp=0110", alu_control_d); end
    endtask

    task automatic test_load_stall();
        if_instruction = 32'h8C04_FFFC; if_pc_plus4 = 32'h200;   // lw $4,-4($0)
        step();
        total++; if (sign_imm_d !== 32'hFFFF_FFFC) begin bad++; $display("FAIL lw_imm got=%h exp=fffffffc", sign_imm_d); end
        total++; if (data2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL lw_data2 got=%h exp=fffffffc", data2); end
        total++; if ({mem_to_reg_d, alu_src_d, reg_write_d} !== 3'b111) begin bad++; $display("FAIL lw_ctrl got=%b exp=111", {mem_to_reg_d, alu_src_d, reg_write_d}); end
        if_instruction = 32'h0084_2820;   // add $5,$4,$4
        step();
        if_instruction = 32'h8C09_0000;
        total++; if ({hazard_detected, stall_f} !== 2'b11) begin bad++; $display("FAIL raw_hazard got=%b exp=11", {hazard_detected, stall_f}); end
        total++; if ({reg_write_d, reg_dst_d, alu_op_d} !== 4'b0) begin bad++; $display("FAIL raw_bubble got=%b exp=0000", {reg_write_d, reg_dst_d, alu_op_d}); end
        step();
        total++; if (rd_d !== 5'd5 || hazard_detected !== 1'b1) begin bad++; $display("FAIL raw_hold got rd=%0d hz=%b exp rd=5 hz=1", rd_d, hazard_detected); end
        wb_reg_write = 1'b1; wb_write_reg = 5'd4; wb_result = 32'd7;
        #1;
        total++; if (hazard_detected !== 1'b0) begin bad++; $display("FAIL wb_release got=%b exp=0", hazard_detected); end
        total++; if (data1 !== 32'd7) begin bad++; $display("FAIL wb_bypass got=%h exp=7", data1); end
        if_instruction = 32'h0;
        step();
        wb_reg_write = 1'b0;
        total++; if (rd_d !== 5'd0) begin bad++; $display("FAIL after_release got rd=%0d exp=0", rd_d); end
        step();
    endtask

    task automatic test_zero_reg();
        wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_result = 32'd9;
        if_instruction = 32'h2000_0001;   // addi $0,$0,1 must not mark $0
        step();
        if_instruction = 32'h0000_3820;   // add $7,$0,$0
        step();
        if_instruction = 32'h0;
        total++; if (data1 !== 32'h0) begin bad++; $display("FAIL zero_read got=%h exp=0", data1); end
        total++; if (hazard_detected !== 1'b0) begin bad++; $display("FAIL zero_pending got=%b exp=0", hazard_detected); end
        wb_reg_write = 1'b0;
        step();
    endtask

    task automatic test_flush();
        flush_d = 1'b1; if_instruction = 32'h0022_1820;
        step();
        flush_d = 1'b0; if_instruction = 32'h0;
        total++; if ({reg_write_d, reg_dst_d, alu_op_d} !== 4'b0) begin bad++; $display("FAIL flush_ctrl got=%b exp=0000", {reg_write_d, reg_dst_d, alu_op_d}); end
        total++; if ({rs_d, rt_d, rd_d} !== 15'h0) begin bad++; $display("FAIL flush_fields got=%0d,%0d,%0d exp=0,0,0", rs_d, rt_d, rd_d); end
    endtask

    task automatic test_reset_stall();
        if_instruction = 32'h8C08_0000;   // lw $8,0($0)
        step();
        if_instruction = 32'h0108_4820;   // add $9,$8,$8
        step();
        total++; if (hazard_detected !== 1'b1) begin bad++; $display("FAIL rst_stall_pre got=%b exp=1", hazard_detected); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (hazard_detected !== 1'b0) begin bad++; $display("FAIL rst_stall_clear got=%b exp=0", hazard_detected); end
        step();
        total++; if (hazard_detected !== 1'b0 || reg_write_d !== 1'b1) begin bad++; $display("FAIL rst_pending_clear got hz=%b rw=%b exp hz=0 rw=1", hazard_detected, reg_write_d); end
        if_instruction = 32'h0;
        step();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_alu_funct();
        test_branch();
        test_load_stall();
        test_zero_reg();
        test_flush();
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
